rbz_spi_loader: RTL and testbench



---
 rtl/rbz_spi_loader_pkg.sv | 18 +
 rtl/rbz_spi_loader_shifter.sv | 126 ++++++++++++
 rtl/rbz_spi_loader.sv | 119 +++++++++++
 tb/tb_rbz_spi_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbz_spi_loader_pkg.sv
// Shared definitions for the rbzero SPI loader: 3-bit state encodings,
// channel identifiers and the divider / bit-counter widths.
package rbz_spi_loader_pkg;

  localparam int unsigned DIV_W = 8;   // divider counter (HALF/GAP up to 255)
  localparam int unsigned BIT_W = 7;   // bit counter (frames up to 127 bits)

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic CH_VEC = 1'b0;
  localparam logic CH_REG = 1'b1;

endpackage

// File: rtl/rbz_spi_loader_shifter.sv
// spi_frame_shifter: SPI mode-0, MSB-first serialiser for one frame of up to
// MAX_BITS bits. Frame length is a run-time input. All bus outputs registered.
module spi_frame_shifter
  import rbz_spi_loader_pkg::*;
#(
  parameter int unsigned MAX_BITS = 74,
  parameter int unsigned HALF     = 2,
  parameter int unsigned GAP      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MAX_BITS-1:0] frame,
  input  logic [BIT_W-1:0]    frame_len,
  output logic                idle,
  output logic                ack,
  output logic                done,
  output logic                busy,
  output logic                csb,
  output logic                sclk,
  output logic                mosi
);

  localparam logic [DIV_W-1:0] HALF_L  = DIV_W'(HALF);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(HALF - 1);
  localparam logic [DIV_W-1:0] GAP_M1  = DIV_W'(GAP - 1);
  localparam logic [BIT_W-1:0] MAX_L   = BIT_W'(MAX_BITS);

  logic [2:0]          state;
  logic [DIV_W-1:0]    div;
  logic [BIT_W-1:0]    bit_cnt;
  logic [MAX_BITS-1:0] shreg;

  assign idle = (state == ST_IDLE);

  // Phase sequencer: each phase's outputs are registered on entry and held
  // while the divider counts down. SETUP is loaded with HALF (not HALF-1) so
  // the grant cycle keeps csb high before the HALF csb-low setup cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ack     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            div     <= HALF_L;
            shreg   <= frame << (MAX_L - frame_len);
            bit_cnt <= frame_len - 1'b1;
            ack     <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (div != '0) begin
            div  <= div - 1'b1;
            csb  <= 1'b0;
            mosi <= shreg[MAX_BITS-1];
          end else begin
            state <= ST_HIGH;
            sclk  <= 1'b1;
            div   <= HALF_M1;
          end
        end
        ST_HIGH: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else begin
            sclk <= 1'b0;
            div  <= HALF_M1;
            if (bit_cnt == '0) begin
              state <= ST_END;
            end else begin
              state   <= ST_LOW;
              shreg   <= {shreg[MAX_BITS-2:0], 1'b0};
              mosi    <= shreg[MAX_BITS-2];
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_LOW: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else begin
            state <= ST_HIGH;
            sclk  <= 1'b1;
            div   <= HALF_M1;
          end
        end
        ST_END: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else begin
            state <= ST_GAP;
            csb   <= 1'b1;
            mosi  <= 1'b0;
            div   <= GAP_M1;
            done  <= (GAP == 1);
          end
        end
        ST_GAP: begin
          if (div != '0) begin
            div  <= div - 1'b1;
            done <= (div == DIV_W'(1));
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rbz_spi_loader.sv
// rbz_spi_loader: round-robin SPI loader feeding rbzero's vec and reg SPI
// peripherals through one shared frame shifter.
// Optional build macro RBZ_SPI_LOADER_VBLANK_SYNC_EN: vec requests are only
// granted while i_vblank is high.
module rbz_spi_loader
  import rbz_spi_loader_pkg::*;
#(
  parameter int unsigned VEC_BITS = 74,
  parameter int unsigned REG_BITS = 16,
  parameter int unsigned HALF     = 2,
  parameter int unsigned GAP      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_vec_req,
  input  logic [VEC_BITS-1:0] i_vec_data,
  output logic                o_vec_ack,
  output logic                o_vec_done,
  input  logic                i_reg_req,
  input  logic [REG_BITS-1:0] i_reg_data,
  output logic                o_reg_ack,
  output logic                o_reg_done,
  input  logic                i_vblank,
  output logic                o_busy,
  output logic                o_vec_csb,
  output logic                o_vec_sclk,
  output logic                o_vec_mosi,
  output logic                o_reg_csb,
  output logic                o_reg_sclk,
  output logic                o_reg_mosi
);

  localparam int unsigned MAX_BITS = (VEC_BITS > REG_BITS) ? VEC_BITS : REG_BITS;

  logic                vec_elig;
  logic                reg_elig;
  logic                grant;
  logic                grant_ch;
  logic                last_ch;
  logic                cur_ch;
  logic [MAX_BITS-1:0] sh_frame;
  logic [BIT_W-1:0]    sh_len;
  logic                sh_idle;
  logic                sh_ack;
  logic                sh_done;
  logic                sh_csb;
  logic                sh_sclk;
  logic                sh_mosi;

`ifdef RBZ_SPI_LOADER_VBLANK_SYNC_EN
  assign vec_elig = i_vec_req & i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = i_vblank;
  assign vec_elig = i_vec_req;
`endif
  assign reg_elig = i_reg_req;
  assign grant    = sh_idle & (vec_elig | reg_elig);

  // Round-robin choice and frame/length mux for the shifter load.
  always_comb begin
    grant_ch = CH_VEC;
    if (vec_elig && reg_elig) grant_ch = ~last_ch;
    else if (reg_elig)        grant_ch = CH_REG;
    sh_frame = '0;
    if (grant_ch == CH_VEC) begin
      sh_frame[VEC_BITS-1:0] = i_vec_data;
      sh_len = BIT_W'(VEC_BITS);
    end else begin
      sh_frame[REG_BITS-1:0] = i_reg_data;
      sh_len = BIT_W'(REG_BITS);
    end
  end

  // Latch the granted channel and flip the round-robin pointer per grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ch <= CH_REG;
      cur_ch  <= CH_VEC;
    end else if (grant) begin
      last_ch <= grant_ch;
      cur_ch  <= grant_ch;
    end
  end

  spi_frame_shifter #(
    .MAX_BITS(MAX_BITS),
    .HALF    (HALF),
    .GAP     (GAP)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (grant),
    .frame    (sh_frame),
    .frame_len(sh_len),
    .idle     (sh_idle),
    .ack      (sh_ack),
    .done     (sh_done),
    .busy     (o_busy),
    .csb      (sh_csb),
    .sclk     (sh_sclk),
    .mosi     (sh_mosi)
  );

  // cur_ch only changes on a grant edge, when the shifter bus is idle, so the
  // demux of registered shifter outputs cannot glitch the unselected bus.
  assign o_vec_csb  = (cur_ch == CH_VEC) ? sh_csb  : 1'b1;
  assign o_vec_sclk = (cur_ch == CH_VEC) & sh_sclk;
  assign o_vec_mosi = (cur_ch == CH_VEC) & sh_mosi;
  assign o_reg_csb  = (cur_ch == CH_REG) ? sh_csb  : 1'b1;
  assign o_reg_sclk = (cur_ch == CH_REG) & sh_sclk;
  assign o_reg_mosi = (cur_ch == CH_REG) & sh_mosi;

  assign o_vec_ack  = sh_ack  & (cur_ch == CH_VEC);
  assign o_reg_ack  = sh_ack  & (cur_ch == CH_REG);
  assign o_vec_done = sh_done & (cur_ch == CH_VEC);
  assign o_reg_done = sh_done & (cur_ch == CH_REG);

endmodule

// File: tb/tb_rbz_spi_loader.sv
// Self-checking bench for rbz_spi_loader: a scoreboard of expected frames is
// filled as requests are driven and drained by a bus monitor on each done.
// Bus index: 0 = vec, 1 = reg (HALF=2,GAP=2 unit); 2 = reg, 3 = vec (HALF=1,GAP=1 unit).
module tb_rbz_spi_loader;

  typedef struct {
    int          bus;
    logic [73:0] data;
    int          len;
    int          low;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        vec_req, reg_req, vblank, d1_reg_req;
  logic [73:0] vec_data;
  logic [15:0] reg_data, d1_reg_data;
  logic        vec_ack, vec_done, reg_ack, reg_done, busy;
  logic        vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi;
  logic        d1_vec_ack, d1_vec_done, d1_reg_ack, d1_reg_done, d1_busy;
  logic        d1_vec_csb, d1_vec_sclk, d1_vec_mosi, d1_reg_csb, d1_reg_sclk, d1_reg_mosi;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb[$];

  localparam logic [73:0] ALT = {37{2'b10}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rbz_spi_loader #(.VEC_BITS(74), .REG_BITS(16), .HALF(2), .GAP(2)) dut (
    .clk(clk), .reset(reset),
    .i_vec_req(vec_req), .i_vec_data(vec_data), .o_vec_ack(vec_ack), .o_vec_done(vec_done),
    .i_reg_req(reg_req), .i_reg_data(reg_data), .o_reg_ack(reg_ack), .o_reg_done(reg_done),
    .i_vblank(vblank), .o_busy(busy),
    .o_vec_csb(vec_csb), .o_vec_sclk(vec_sclk), .o_vec_mosi(vec_mosi),
    .o_reg_csb(reg_csb), .o_reg_sclk(reg_sclk), .o_reg_mosi(reg_mosi)
  );

  rbz_spi_loader #(.VEC_BITS(74), .REG_BITS(16), .HALF(1), .GAP(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_vec_req(1'b0), .i_vec_data(74'd0), .o_vec_ack(d1_vec_ack), .o_vec_done(d1_vec_done),
    .i_reg_req(d1_reg_req), .i_reg_data(d1_reg_data), .o_reg_ack(d1_reg_ack), .o_reg_done(d1_reg_done),
    .i_vblank(1'b0), .o_busy(d1_busy),
    .o_vec_csb(d1_vec_csb), .o_vec_sclk(d1_vec_sclk), .o_vec_mosi(d1_vec_mosi),
    .o_reg_csb(d1_reg_csb), .o_reg_sclk(d1_reg_sclk), .o_reg_mosi(d1_reg_mosi)
  );

  wire [3:0] bcsb  = {d1_vec_csb,  d1_reg_csb,  reg_csb,  vec_csb};
  wire [3:0] bsclk = {d1_vec_sclk, d1_reg_sclk, reg_sclk, vec_sclk};
  wire [3:0] bmosi = {d1_vec_mosi, d1_reg_mosi, reg_mosi, vec_mosi};
  wire [3:0] back  = {d1_vec_ack,  d1_reg_ack,  reg_ack,  vec_ack};
  wire [3:0] bdone = {d1_vec_done, d1_reg_done, reg_done, vec_done};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor state per bus
  logic [73:0] got [4];
  int   nbits [4], low_cnt [4], ack_cyc [4], first_low [4];
  int   idle_viol [4], ack_cnt [4], done_cnt [4];
  bit   active [4];
  logic [3:0] prev_sclk = '0, prev_csb = '1;
  logic prev_busy = 1'b0;
  int   fall_cyc = 0;
  int   tog_viol = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      got[i] = '0; nbits[i] = 0; low_cnt[i] = 0; ack_cyc[i] = 0; first_low[i] = -1;
      idle_viol[i] = 0; ack_cnt[i] = 0; done_cnt[i] = 0; active[i] = 0;
    end
  end

  // Bus monitor: capture bits on sclk rise, time csb, pop scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    for (int b = 0; b < 4; b++) begin
      if (reset) begin
        active[b] = 0; nbits[b] = 0; low_cnt[b] = 0; got[b] = '0; first_low[b] = -1;
      end else begin
        if (back[b]) begin
          active[b] = 1; ack_cyc[b] = cyc; nbits[b] = 0; low_cnt[b] = 0;
          got[b] = '0; first_low[b] = -1; ack_cnt[b]++;
        end
        if (!bcsb[b]) begin
          low_cnt[b]++;
          if (first_low[b] < 0) first_low[b] = cyc;
          if (b == 2 && !prev_csb[b] && bsclk[b] == prev_sclk[b]) tog_viol++;
          if (bsclk[b] && !prev_sclk[b]) begin
            got[b] = {got[b][72:0], bmosi[b]};
            nbits[b]++;
          end
        end
        if (!active[b] && !(bcsb[b] && !bsclk[b] && !bmosi[b])) idle_viol[b]++;
        if (bdone[b]) begin
          done_cnt[b]++;
          active[b] = 0;
          if (sb.size() == 0) begin
            check("done_with_empty_sb", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("done_bus", b, e.bus);
            check("frame_bits", got[b], e.data);
            check("bit_count", nbits[b], e.len);
            check("csb_low_cycles", low_cnt[b], e.low);
            check("csb_first_low", first_low[b] - ack_cyc[b], 1);
            check("done_latency", cyc - ack_cyc[b], e.low + e.gap);
          end
        end
      end
      prev_sclk[b] = bsclk[b];
      prev_csb[b]  = bcsb[b];
    end
  end

  task automatic push(input int bus, input logic [73:0] data, input int len);
    exp_t e;
    int h, g;
    h = (bus >= 2) ? 1 : 2;
    g = (bus >= 2) ? 1 : 2;
    e.bus = bus; e.data = data; e.len = len;
    e.low = h * (1 + 2 * len); e.gap = g;
    sb.push_back(e);
  endtask

  task automatic send(input int bus, input logic [73:0] data, input int len);
    int n;
    push(bus, data, len);
    case (bus)
      0: begin vec_data = data; vec_req = 1'b1; end
      1: begin reg_data = data[15:0]; reg_req = 1'b1; end
      default: begin d1_reg_data = data[15:0]; d1_reg_req = 1'b1; end
    endcase
    n = 0;
    while (!back[bus] && n < 500) begin @(negedge clk); n++; end
    check("ack_seen", back[bus], 1);
    case (bus)
      0: vec_req = 1'b0;
      1: reg_req = 1'b0;
      default: d1_reg_req = 1'b0;
    endcase
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || d1_busy) && n < 3000) begin @(negedge clk); n++; end
    check(tag, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int va, vd, rd, n, acks, t;
    logic [73:0] v0, v1, v2;
    logic [15:0] r0, r1;
    reset = 1'b1; vec_req = 1'b0; reg_req = 1'b0; vblank = 1'b0; d1_reg_req = 1'b0;
    vec_data = '0; reg_data = '0; d1_reg_data = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi,
           busy, vec_ack, reg_ack, vec_done, reg_done}, 11'b100_100_00000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single reg frame
    send(1, 74'hA5C3, 16);
    wait_drain("reg_frame_drain");

    // Alternating vec frame, exactly one ack and one done
    va = ack_cnt[0]; vd = done_cnt[0];
    send(0, ALT, 74);
    wait_drain("vec_frame_drain");
    check("vec_ack_once", ack_cnt[0] - va, 1);
    check("vec_done_once", done_cnt[0] - vd, 1);

    // Both requests from reset release: vec, reg, vec, reg back to back
    v0 = {$urandom, $urandom, $urandom}; v1 = {$urandom, $urandom, $urandom};
    r0 = 16'($urandom); r1 = 16'($urandom);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push(0, v0, 74); push(1, {58'd0, r0}, 16); push(0, v1, 74); push(1, {58'd0, r1}, 16);
    reset = 1'b0;
    vec_data = v0; reg_data = r0; vec_req = 1'b1; reg_req = 1'b1;
    acks = 0; n = 0;
    while (acks < 4 && n < 3000) begin
      @(negedge clk); n++;
      if (vec_ack || reg_ack) begin
        if (acks > 0) check("grant_gap", cyc - fall_cyc, 1);
        acks++;
        if (vec_ack) begin
          if (acks == 1) vec_data = v1;
          else begin vec_req = 1'b0; vec_data = '1; end
        end else begin
          if (acks == 2) reg_data = r1;
          else begin reg_req = 1'b0; reg_data = '1; end
        end
      end
    end
    check("rr_grant_count", acks, 4);
    wait_drain("rr_drain");

    // Reset in the middle of a reg frame
    reg_data = 16'hFFFF; reg_req = 1'b1;
    n = 0;
    while (!reg_ack && n < 100) begin @(negedge clk); n++; end
    check("abort_ack_seen", reg_ack, 1);
    reg_req = 1'b0;
    n = 0;
    while (nbits[1] < 5 && n < 200) begin @(negedge clk); n++; end
    check("abort_reached_bit5", nbits[1] >= 5, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bus_idle", {reg_csb, reg_sclk, reg_mosi, busy}, 4'b1000);
    rd = done_cnt[1];
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_done", done_cnt[1] - rd, 0);
    send(1, 74'h3C5A, 16);
    wait_drain("after_abort_drain");

    // vblank gating of vec requests
    v2 = {$urandom, $urandom, $urandom};
    vblank = 1'b0;
`ifdef RBZ_SPI_LOADER_VBLANK_SYNC_EN
    va = ack_cnt[0];
    vec_data = v2; vec_req = 1'b1;
    repeat (40) @(negedge clk);
    check("vblank_blocks_vec", ack_cnt[0] - va, 0);
    send(1, 74'h1234, 16);
    push(0, v2, 74);
    rd = done_cnt[1];
    n = 0;
    while (done_cnt[1] == rd && n < 200) begin @(negedge clk); n++; end
    check("vblank_reg_served", done_cnt[1] - rd, 1);
    vblank = 1'b1; t = cyc;
    n = 0;
    while (!vec_ack && n < 20) begin @(negedge clk); n++; end
    check("vblank_vec_ack", vec_ack, 1);
    check("vblank_vec_latency", (cyc - t) <= 3, 1);
    vec_req = 1'b0;
`else
    t = cyc;
    send(0, v2, 74);
    check("novblank_vec_latency", (cyc - t) <= 3, 1);
`endif
    wait_drain("vblank_drain");

    // HALF=1, GAP=1 unit
    send(2, 74'h8001, 16);
    wait_drain("half1_drain");
    check("half1_sclk_toggle", tog_viol, 0);

    for (int i = 0; i < 4; i++) check("idle_bus_quiet", idle_viol[i], 0);
    check("sb_empty_at_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
